down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 97 +++++++++
 tb/tb_down_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// down_counter
//   Loadable down-counter with one-shot and periodic (auto-reload) modes.
//   A load captures the start value into both the counter and a reload
//   register. While running, each enabled cycle decrements the counter. When an
//   enabled cycle sees count == 1, the counter either reloads (periodic) or
//   stops at 0 in HOLD (one-shot). In both cases tc pulses for one cycle.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   load        : load request (wins over en and terminal-count detection)
//   load_val    : start / reload value, WIDTH bits
//   en          : count enable, one decrement per enabled cycle
//   auto_reload : 1 = periodic, 0 = one-shot (only looked at on the terminal cycle)
//   count       : registered counter value
//   tc          : registered terminal-count pulse, one cycle wide
//   busy        : state == RUN
//   done        : state == HOLD
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            // A zero load would leave RUN with nothing to count; park in IDLE
            // so RUN is never entered with count == 0.
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    // reload_q is nonzero here: RUN is only reached via a
                    // nonzero load, which also wrote reload_q.
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = HOLD;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        count = count_q;
        tc    = tc_q;
        busy  = (state_q == RUN);
        done  = (state_q == HOLD);
    end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       auto_reload;
    logic [7:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    down_counter #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic t,
                           input logic b, input logic d);
        chk({tag, ".count"}, {24'd0, count}, {24'd0, c});
        chk({tag, ".tc"},    {31'd0, tc},    {31'd0, t});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, done},  {31'd0, d});
    endtask

    // Advance one rising edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] per_cnt [12];
        logic       per_tc  [12];
        logic [7:0] gap_cnt [4];
        logic       gap_tc  [4];
        logic       gap_en  [4];
        int         tc_pulses;

        per_cnt = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
        per_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        gap_en  = '{1'b1, 1'b0, 1'b0, 1'b1};
        gap_cnt = '{8'd1, 8'd1, 8'd1, 8'd0};
        gap_tc  = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; load = 1'b0; load_val = 8'd0; en = 1'b1; auto_reload = 1'b0;

        // Reset state, with en already high
        tick();
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        // First edge after release, no load: nothing asserts
        tick();
        chk_all("post_rst_idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, load 3
        load = 1'b1; load_val = 8'd3; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        chk_all("os_load", 8'd3, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("os_2", 8'd2, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("os_1", 8'd1, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("os_0", 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_all("os_hold", 8'd0, 1'b0, 1'b0, 1'b1);
        end

        // Periodic, load 4, 12 enabled cycles
        load = 1'b1; load_val = 8'd4; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        chk_all("per_load", 8'd4, 1'b0, 1'b1, 1'b0);
        tc_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            // auto_reload toggled off away from the terminal cycle must not matter
            auto_reload = (per_cnt[i] == 8'd1) ? 1'b0 : 1'b1;
            auto_reload = (i == 1 || i == 5) ? 1'b0 : 1'b1;
            tick();
            chk_all("per_step", per_cnt[i], per_tc[i], 1'b1, 1'b0);
            if (tc) tc_pulses++;
        end
        chk("per_pulses", tc_pulses, 3);

        // Enable gaps, load 2, en 1,0,0,1
        load = 1'b1; load_val = 8'd2; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        chk_all("gap_load", 8'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            en = gap_en[i];
            tick();
            chk_all("gap_step", gap_cnt[i], gap_tc[i], !gap_tc[i], gap_tc[i]);
        end

        // Load collision at count == 1 with en = 1
        en = 1'b1;
        load = 1'b1; load_val = 8'd3;
        tick();
        load = 1'b0;
        tick(); tick();
        chk_all("col_pre", 8'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 8'd5;
        tick();
        chk_all("col_load5", 8'd5, 1'b0, 1'b1, 1'b0);
        load_val = 8'd0;
        tick();
        load = 1'b0;
        chk_all("col_load0", 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("col_idle_en", 8'd0, 1'b0, 1'b0, 1'b0);

        // Periodic with reload == 1: tc after every enabled cycle
        load = 1'b1; load_val = 8'd1; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        chk_all("r1_load", 8'd1, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("r1_a", 8'd1, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("r1_b", 8'd1, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk_all("r1_gap", 8'd1, 1'b0, 1'b1, 1'b0);

        // Async reset mid-cycle at count 0x80
        load = 1'b1; load_val = 8'h80; auto_reload = 1'b0; en = 1'b0;
        tick();
        load = 1'b0;
        chk_all("ar_pre", 8'h80, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk_all("ar_async", 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1; en = 1'b1;
        tick(); chk_all("ar_after", 8'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("ar_after2", 8'd0, 1'b0, 1'b0, 1'b0);

        // Wide value 0xFF: 255 enabled cycles to tc, no wrap
        load = 1'b1; load_val = 8'hFF; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        chk_all("wide_load", 8'hFF, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 255; k++) begin
            tick();
            chk("wide_count", {24'd0, count}, 32'(255 - k));
            chk("wide_tc", {31'd0, tc}, 32'd0);
        end
        tick();
        chk_all("wide_end", 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("wide_hold", 8'd0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
